// File: rtl/s_des_decrypt_core.sv
// s_des_decrypt_core: iterative S-DES decryptor with one block in flight.
// A block is accepted in IDLE, takes KEYGEN, FK2 and FK1, and waits in OUT
// until the consumer takes it.
// Optional feature macro: S_DES_KEY_CACHE_EN. When it is defined, a repeated
// key skips KEYGEN and reuses the stored subkeys.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on the FSM state. out_valid depends only on
// the FSM state, never on out_ready. Once out_valid is high, it and the data
// stay stable until the transfer.
module s_des_decrypt_core #(
   parameter int CNT_W         = 16,
   parameter int ZERO_IDLE_OUT = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       ciphertext,
   input  logic [9:0]       key,
   input  logic [31:0]      S0,
   input  logic [31:0]      S1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       decryptedtext,
   output logic             busy,
   output logic [CNT_W-1:0] blk_count
);

   typedef enum logic [2:0] {IDLE, KEYGEN, FK2, FK1, OUT} state_t;

   state_t      state, state_d;
   logic        accept;
   logic        hit;
   logic [7:0]  ct_q, k1_q, k2_q, mid_q, dt_q;
   logic [9:0]  key_q;
   logic [31:0] s0_q, s1_q;
   logic [7:0]  ip_ct;
   logic [9:0]  key_p10;

   // Bit b of an S-DES vector (1-based, MSB first) is vec[WIDTH-b].
   function automatic logic [9:0] p10(input logic [9:0] k);
      return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
   endfunction

   function automatic logic [7:0] p8(input logic [9:0] k);
      return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
   endfunction

   function automatic logic [4:0] rol1(input logic [4:0] h);
      return {h[3:0], h[4]};
   endfunction

   function automatic logic [4:0] rol3(input logic [4:0] h);
      return {h[1:0], h[4:2]};
   endfunction

   function automatic logic [7:0] ip(input logic [7:0] b);
      return {b[6], b[2], b[5], b[7], b[4], b[0], b[3], b[1]};
   endfunction

   function automatic logic [7:0] ip_inv(input logic [7:0] b);
      return {b[4], b[7], b[5], b[3], b[1], b[6], b[0], b[2]};
   endfunction

   function automatic logic [7:0] ep(input logic [3:0] r);
      return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
   endfunction

   function automatic logic [3:0] p4(input logic [3:0] s);
      return {s[2], s[0], s[1], s[3]};
   endfunction

   // Row is {b1,b4}, column is {b2,b3}; entry row*4+col sits at bits [2i+1:2i].
   function automatic logic [1:0] sbox(input logic [31:0] s, input logic [3:0] x);
      logic [4:0] base;
      base = {x[3], x[0], x[2], x[1], 1'b0};
      return s[base +: 2];
   endfunction

   function automatic logic [3:0] f_round(input logic [3:0] r, input logic [7:0] sk,
                                          input logic [31:0] s0, input logic [31:0] s1);
      logic [7:0] t;
      t = ep(r) ^ sk;
      return p4({sbox(s0, t[7:4]), sbox(s1, t[3:0])});
   endfunction

   assign ip_ct   = ip(ct_q);
   assign key_p10 = p10(key_q);

`ifdef S_DES_KEY_CACHE_EN
   logic cache_vld;
   assign hit = cache_vld && (key == key_q);
`else
   assign hit = 1'b0;
`endif

   // Next-state and handshake decode.
   always_comb begin
      state_d  = state;
      in_ready = 1'b0;
      busy     = 1'b1;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = hit ? FK2 : KEYGEN;
            end
         end
         KEYGEN:  state_d = FK2;
         FK2:     state_d = FK1;
         FK1:     state_d = OUT;
         OUT:     if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign out_valid     = (state == OUT);
   assign decryptedtext = (ZERO_IDLE_OUT != 0 && state != OUT) ? 8'h00 : dt_q;

   // Control registers: state, result, completed-block counter, cache flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         dt_q      <= 8'h00;
         blk_count <= '0;
`ifdef S_DES_KEY_CACHE_EN
         cache_vld <= 1'b0;
`endif
      end else begin
         state <= state_d;
         if (state == FK1)
            dt_q <= ip_inv({mid_q[7:4] ^ f_round(mid_q[3:0], k1_q, s0_q, s1_q), mid_q[3:0]});
         if (state == OUT && out_ready)
            blk_count <= blk_count + 1'b1;
`ifdef S_DES_KEY_CACHE_EN
         // Subkeys become stale the moment a new key is captured on a miss.
         if (accept && !hit)
            cache_vld <= 1'b0;
         else if (state == KEYGEN)
            cache_vld <= 1'b1;
`endif
      end
   end

   // Datapath registers: captured inputs, subkeys and the swapped mid-round.
   always_ff @(posedge clk) begin
      if (accept) begin
         ct_q  <= ciphertext;
         key_q <= key;
         s0_q  <= S0;
         s1_q  <= S1;
      end
      if (state == KEYGEN) begin
         k1_q <= p8({rol1(key_p10[9:5]), rol1(key_p10[4:0])});
         k2_q <= p8({rol3(key_p10[9:5]), rol3(key_p10[4:0])});
      end
      if (state == FK2)
         mid_q <= {ip_ct[3:0], ip_ct[7:4] ^ f_round(ip_ct[3:0], k2_q, s0_q, s1_q)};
   end

endmodule

// File: tb/tb_s_des_decrypt_core.sv
// tb_s_des_decrypt_core: directed bench for s_des_decrypt_core. Expected
// plaintexts come from a table-driven S-DES encryption model (round trip).
`timescale 1ns/1ps
module tb_s_des_decrypt_core;

   localparam logic [31:0] SBOX0 = 32'b10110111110110000001101110110001;
   localparam logic [31:0] SBOX1 = 32'b11000110000100111101001011100100;
   localparam logic [9:0]  KEY_A = 10'b1010000010;

   localparam int P10_T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
   localparam int P8_T  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
   localparam int IP_T  [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
   localparam int IPI_T [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
   localparam int EP_T  [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
   localparam int P4_T  [4]  = '{2, 4, 3, 1};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  ct_i = 8'h00;
   logic [9:0]  key_i = 10'h000;
   logic [31:0] s0_i = SBOX0;
   logic [31:0] s1_i = SBOX1;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  dt;
   logic        busy;
   logic [15:0] blk_count;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          n_sent = 0;
   logic [7:0]  exp_q [$];
   logic        m_cache_vld = 1'b0;
   logic [9:0]  m_cache_key = 10'h000;

   s_des_decrypt_core #(.CNT_W(16), .ZERO_IDLE_OUT(0)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .ciphertext(ct_i), .key(key_i), .S0(s0_i), .S1(s1_i),
      .out_valid(out_valid), .out_ready(out_ready), .decryptedtext(dt),
      .busy(busy), .blk_count(blk_count)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- model ----------------
   function automatic logic [9:0] m_p10(input logic [9:0] k);
      logic [9:0] r;
      for (int i = 0; i < 10; i++) r[9-i] = k[10-P10_T[i]];
      return r;
   endfunction

   function automatic logic [7:0] m_p8(input logic [9:0] k);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[7-i] = k[10-P8_T[i]];
      return r;
   endfunction

   function automatic logic [7:0] m_perm8(input logic [7:0] b, input bit inv);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[7-i] = inv ? b[8-IPI_T[i]] : b[8-IP_T[i]];
      return r;
   endfunction

   function automatic logic [9:0] m_ls(input logic [9:0] v, input int n);
      for (int i = 0; i < n; i++) v = {v[8:5], v[9], v[3:0], v[4]};
      return v;
   endfunction

   function automatic logic [1:0] m_sbox(input logic [31:0] s, input int row, input int col);
      int idx;
      idx = row * 4 + col;
      return s[idx*2 +: 2];
   endfunction

   function automatic logic [3:0] m_f(input logic [3:0] r, input logic [7:0] sk);
      logic [7:0] e, t;
      logic [3:0] s, o;
      for (int i = 0; i < 8; i++) e[7-i] = r[4-EP_T[i]];
      t = e ^ sk;
      s[3:2] = m_sbox(SBOX0, 2*int'(t[7]) + int'(t[4]), 2*int'(t[6]) + int'(t[5]));
      s[1:0] = m_sbox(SBOX1, 2*int'(t[3]) + int'(t[0]), 2*int'(t[2]) + int'(t[1]));
      for (int i = 0; i < 4; i++) o[3-i] = s[4-P4_T[i]];
      return o;
   endfunction

   function automatic logic [7:0] m_enc(input logic [7:0] p, input logic [9:0] k);
      logic [7:0] k1, k2, x;
      logic [3:0] l, r, t;
      k1 = m_p8(m_ls(m_p10(k), 1));
      k2 = m_p8(m_ls(m_p10(k), 3));
      x  = m_perm8(p, 1'b0);
      l  = x[7:4];
      r  = x[3:0];
      l  = l ^ m_f(r, k1);
      t  = l; l = r; r = t;
      l  = l ^ m_f(r, k2);
      return m_perm8({l, r}, 1'b1);
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Scoreboard: every output transfer must match the next expected plaintext.
   always @(negedge clk) begin
      logic [7:0] e;
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0)
            check("sb_unexpected", 32'd1, 32'd0);
         else begin
            e = exp_q.pop_front();
            check("sb_data", 32'(dt), 32'(e));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      n_sent = 0;
      exp_q.delete();
      m_cache_vld = 1'b0;
   endtask

   task automatic send(input logic [7:0] c, input logic [9:0] k, input logic [7:0] exp_pt,
                       input bit push, input bit hold, output int acc_cyc, output int exp_lat);
      int n;
      ct_i = c;
      key_i = k;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
      exp_lat = 3;
`ifdef S_DES_KEY_CACHE_EN
      if (m_cache_vld && m_cache_key == k) exp_lat = 2;
      m_cache_vld = 1'b1;
      m_cache_key = k;
`endif
      if (push) begin
         exp_q.push_back(exp_pt);
         n_sent++;
      end
      tick();
      acc_cyc = cyc;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag, input int exp_lat);
      int lat;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!out_valid && lat < 20);
      check(tag, 32'(lat), 32'(exp_lat));
   endtask

   // Watchdog.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int acc, lat;
      int acc_b [3];
      int lat_b [3];
      logic [7:0] pt_b [3];
      logic [9:0] keys [5];
      logic [7:0] p;

      pt_b = '{8'h72, 8'hA5, 8'h3C};
      keys = '{KEY_A, 10'b0000000000, 10'b1111111111, 10'b0110101001, KEY_A};

      do_reset();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_dt", 32'(dt), 32'd0);
      check("rst_blk_count", 32'(blk_count), 32'd0);

      // Single block with the textbook vector.
      send(8'b01110111, KEY_A, 8'b01110010, 1'b1, 1'b0, acc, lat);
      wait_out("single_lat", 3);
      check("single_dt", 32'(dt), 32'h72);
      check("single_blk_before", 32'(blk_count), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("single_blk", 32'(blk_count), 32'd1);
      check("single_valid_drop", 32'(out_valid), 32'd0);
      check("single_in_ready", 32'(in_ready), 32'd1);
      check("single_dt_hold", 32'(dt), 32'h72);

      // Backpressure: result must hold while the consumer stalls.
      send(8'b01110111, KEY_A, 8'b01110010, 1'b1, 1'b0, acc, lat);
      wait_out("bp_lat", lat);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_dt", 32'(dt), 32'h72);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_busy", 32'(busy), 32'd1);
         tick();
      end
      check("bp_blk_hold", 32'(blk_count), 32'd1);
      out_ready = 1'b1;
      tick();
      check("bp_in_ready_after", 32'(in_ready), 32'd1);
      check("bp_blk", 32'(blk_count), 32'd2);

      // Inputs changed right after accept must not affect the result.
      send(8'b01110111, KEY_A, 8'b01110010, 1'b1, 1'b0, acc, lat);
      key_i = 10'b0000000000;
      ct_i = 8'hFF;
      wait_out("chg_lat", lat);
      check("chg_dt", 32'(dt), 32'h72);
      tick();
      check("chg_blk", 32'(blk_count), 32'd3);

      // Reset in FK2 discards the block.
      out_ready = 1'b0;
      send(8'b01110111, KEY_A, 8'h00, 1'b0, 1'b0, acc, lat);
      if (lat == 3) tick();
      reset = 1'b1;
      tick();
      check("rmid_in_ready", 32'(in_ready), 32'd1);
      check("rmid_out_valid", 32'(out_valid), 32'd0);
      check("rmid_dt", 32'(dt), 32'd0);
      check("rmid_blk", 32'(blk_count), 32'd0);
      reset = 1'b0;
      n_sent = 0;
      m_cache_vld = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("rmid_no_output", 32'(out_valid), 32'd0);

      // Back-to-back with in_valid held high.
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++)
         send(m_enc(pt_b[i], KEY_A), KEY_A, pt_b[i], 1'b1, (i < 2), acc_b[i], lat_b[i]);
      check("b2b_gap1", 32'(acc_b[1] - acc_b[0]), 32'(lat_b[0] + 2));
      check("b2b_gap2", 32'(acc_b[2] - acc_b[1]), 32'(lat_b[1] + 2));
      wait_out("b2b_lat", lat_b[2]);
      tick();
      check("b2b_blk", 32'(blk_count), 32'd3);

      // Round-trip sweep over every plaintext with the textbook key.
      for (int v = 0; v < 256; v++) begin
         p = 8'(v);
         send(m_enc(p, KEY_A), KEY_A, p, 1'b1, 1'b0, acc, lat);
         wait_out("sweep_lat", lat);
         tick();
      end

      // A few other keys with random plaintexts.
      foreach (keys[j]) begin
         for (int i = 0; i < 6; i++) begin
            p = 8'($urandom_range(0, 255));
            send(m_enc(p, keys[j]), keys[j], p, 1'b1, 1'b0, acc, lat);
            wait_out("keys_lat", lat);
            tick();
         end
      end

      tick();
      check("final_drain", 32'(exp_q.size()), 32'd0);
      check("final_blk", 32'(blk_count), 32'(16'(n_sent)));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
